// File: rtl/vga_fb_ctrl.sv
// Double-buffered 1-bit framebuffer controller: CPU pixel/swap stores go to the back bank
// of an external RAM, while VGA timing scans the front bank out to the monitor.
module vga_fb_ctrl #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_wmem,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_data,
  output logic        swap_pending,
  output logic        fb_we,
  output logic [19:0] fb_waddr,
  output logic        fb_wdata,
  output logic [19:0] fb_raddr,
  input  logic        fb_rdata,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_pixel
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VLAST  = 10'(V_VISIBLE - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  typedef struct packed {
    logic        we;
    logic [19:0] addr;
    logic        data;
  } fb_wr_t;

  logic [DW-1:0] div;
  logic [9:0]    hcount, vcount, st_x, st_y;
  logic          display_bank;
  logic          tick, commit, hs_n, vs_n, vis, win, swap_req, pix_req;
  fb_wr_t        wr_q;

  always_comb begin
    tick     = (div == DIV_LAST);
    commit   = tick && (hcount == H_LAST) && (vcount == V_VLAST);
    hs_n     = !((hcount >= HS_START) && (hcount < HS_END));
    vs_n     = !((vcount >= VS_START) && (vcount < VS_END));
    vis      = (hcount < H_VIS) && (vcount < V_VIS);
    win      = cpu_wmem && (cpu_addr[31:24] == 8'hF4);
    swap_req = win && (cpu_addr[23:0] == 24'hFFFFFC);
    st_x     = cpu_addr[9:0];
    st_y     = cpu_addr[19:10];
    pix_req  = win && !swap_req && (st_x < H_VIS) && (st_y < V_VIS);
  end

  assign fb_raddr = {display_bank, vcount[8:0], hcount};
  assign fb_we    = wr_q.we;
  assign fb_waddr = wr_q.addr;
  assign fb_wdata = wr_q.data;

  always_ff @(posedge clock) begin
    if (reset) begin
      div          <= '0;
      hcount       <= '0;
      vcount       <= '0;
      display_bank <= 1'b0;
      swap_pending <= 1'b0;
      wr_q         <= '0;
      vga_hs       <= 1'b1;
      vga_vs       <= 1'b1;
      vga_blank_n  <= 1'b0;
      vga_pixel    <= 1'b0;
    end else begin
      div <= tick ? '0 : div + DW'(1);
      if (tick) begin
        hcount <= (hcount == H_LAST) ? '0 : hcount + 10'd1;
        if (hcount == H_LAST)
          vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
      end
      if (commit && swap_pending)
        display_bank <= ~display_bank;
      // A request landing in the commit clock must survive for the next frame
      if (swap_req)
        swap_pending <= 1'b1;
      else if (commit)
        swap_pending <= 1'b0;
      wr_q.we   <= pix_req;
      wr_q.addr <= {~display_bank, st_y[8:0], st_x};
      wr_q.data <= |cpu_data;
      vga_hs      <= hs_n;
      vga_vs      <= vs_n;
      vga_blank_n <= vis;
      vga_pixel   <= vis ? fb_rdata : 1'b0;
    end
  end
endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Randomized + directed bench for vga_fb_ctrl on a shrunken raster, checked against
// an arithmetic frame/bank model and a behavioural framebuffer RAM.
module tb_vga_fb_ctrl;
  localparam int HV = 16, HF = 2, HS = 3, HB = 3;
  localparam int VV = 8,  VF = 1, VS = 2, VB = 2;
  localparam int CD = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT * CD;

  logic        clock = 1'b0, reset = 1'b1, cpu_wmem = 1'b0, fb_rdata = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_data = '0;
  logic        swap_pending, fb_we, fb_wdata, vga_hs, vga_vs, vga_blank_n, vga_pixel;
  logic [19:0] fb_waddr, fb_raddr;
  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  vga_fb_ctrl #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(CD)
  ) dut (
    .clock(clock), .reset(reset), .cpu_wmem(cpu_wmem), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .swap_pending(swap_pending), .fb_we(fb_we),
    .fb_waddr(fb_waddr), .fb_wdata(fb_wdata), .fb_raddr(fb_raddr),
    .fb_rdata(fb_rdata), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_pixel(vga_pixel)
  );

  // external RAM (written by DUT) and the model's own copy
  bit ram[int];
  bit exp_ram[int];
  bit r_we, r_wdata;
  int r_waddr;

  // reference model: raster position derived from clocks since reset
  int m_n = 0, m_waddr = 0;
  bit m_bank = 0, m_pend = 0, m_we = 0, m_wdata = 0;
  bit m_hs = 1, m_vs = 1, m_blank = 0, m_pix = 0;

  function automatic int h_of(input int n); return (n / CD) % HT; endfunction
  function automatic int v_of(input int n); return (n / CD / HT) % VT; endfunction
  function automatic int key(input bit b, input int v, input int h);
    return (int'(b) << 19) | ((v & 511) << 10) | (h & 1023);
  endfunction
  function automatic bit ram_rd(input int k);
    return ram.exists(k) ? ram[k] : 1'b0;
  endfunction
  function automatic bit exp_rd(input int k);
    return exp_ram.exists(k) ? exp_ram[k] : 1'b0;
  endfunction
  function automatic logic [31:0] pix_addr(input int x, input int y);
    return {8'hF4, 4'h0, 10'(y), 10'(x)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input bit rst, input bit wm, input logic [31:0] a, input logic [31:0] d);
    int h0, v0, x, y;
    bit tk, cm, win, sreq, preq, vis0, rd0;
    reset = rst; cpu_wmem = wm; cpu_addr = a; cpu_data = d;
    @(posedge clock);
    h0 = h_of(m_n); v0 = v_of(m_n);
    vis0 = (h0 < HV) && (v0 < VV);
    rd0 = exp_rd(key(m_bank, v0, h0));
    if (m_we) exp_ram[m_waddr] = m_wdata;
    if (rst) begin
      m_n = 0; m_bank = 0; m_pend = 0; m_we = 0;
      m_hs = 1; m_vs = 1; m_blank = 0; m_pix = 0;
    end else begin
      tk   = (m_n % CD) == CD - 1;
      cm   = tk && (h0 == HT - 1) && (v0 == VV - 1);
      win  = wm && (a[31:24] == 8'hF4);
      sreq = win && (a[23:0] == 24'hFFFFFC);
      x = int'(a[9:0]); y = int'(a[19:10]);
      preq = win && !sreq && (x < HV) && (y < VV);
      m_we = preq;
      if (preq) begin
        m_waddr = key(!m_bank, y, x);
        m_wdata = (d != 0);
      end
      if (cm && m_pend) m_bank = !m_bank;
      m_pend  = sreq || (m_pend && !cm);
      m_hs    = !((h0 >= HV + HF) && (h0 < HV + HF + HS));
      m_vs    = !((v0 >= VV + VF) && (v0 < VV + VF + VS));
      m_blank = vis0;
      m_pix   = vis0 && rd0;
      m_n++;
    end
    #1;
    if (r_we) ram[r_waddr] = r_wdata;
    r_we = fb_we; r_waddr = int'(fb_waddr); r_wdata = fb_wdata;
    fb_rdata = ram_rd(int'(fb_raddr));
    chk("fb_we", 32'(fb_we), 32'(m_we));
    if (m_we) begin
      chk("fb_waddr", 32'(fb_waddr), m_waddr);
      chk("fb_wdata", 32'(fb_wdata), 32'(m_wdata));
    end
    chk("swap_pending", 32'(swap_pending), 32'(m_pend));
    chk("vga_hs", 32'(vga_hs), 32'(m_hs));
    chk("vga_vs", 32'(vga_vs), 32'(m_vs));
    chk("vga_blank_n", 32'(vga_blank_n), 32'(m_blank));
    chk("vga_pixel", 32'(vga_pixel), 32'(m_pix));
    chk("fb_raddr", 32'(fb_raddr), key(m_bank, v_of(m_n), h_of(m_n)));
  endtask

  task automatic idle_to_commit(input string tag);
    int budget = 2 * FRAME;
    while (!(((m_n % CD) == CD - 1) && (h_of(m_n) == HT - 1) && (v_of(m_n) == VV - 1))
           && budget > 0) begin
      cyc(0, 0, '0, '0);
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $error("FAIL %s: commit point not reached within %0d clocks", tag, 2 * FRAME);
    end
  endtask

  initial begin
    logic [31:0] a, d;
    bit wm, b0;
    int k;
    repeat (3) cyc(1, 0, '0, '0);
    chk("rst_hs", 32'(vga_hs), 32'd1);
    chk("rst_raddr", 32'(fb_raddr), 32'd0);

    // pixel stores into back bank 1, then data 0, then out-of-range / foreign windows
    cyc(0, 1, pix_addr(5, 2), 32'h1);
    chk("pix_waddr", 32'(fb_waddr), 32'h80805);
    chk("pix_wdata", 32'(fb_wdata), 32'd1);
    cyc(0, 0, '0, '0);
    chk("pix_one_shot", 32'(fb_we), 32'd0);
    cyc(0, 1, pix_addr(5, 2), 32'h0);
    cyc(0, 1, pix_addr(3, VV), 32'h1);
    chk("y_oob", 32'(fb_we), 32'd0);
    cyc(0, 1, pix_addr(HV, 3), 32'h1);
    chk("x_oob", 32'(fb_we), 32'd0);
    cyc(0, 1, 32'hF3000805, 32'h1);
    chk("not_f4", 32'(fb_we), 32'd0);
    for (int i = 0; i < 4; i++) cyc(0, 1, pix_addr(i, 1), 32'h8000_0000);

    // swap request, commit at entry into vertical blank
    cyc(0, 1, 32'hF4FFFFFC, 32'h0);
    chk("swap_set", 32'(swap_pending), 32'd1);
    idle_to_commit("swap1");
    cyc(0, 0, '0, '0);
    chk("swap_bank", 32'(fb_raddr[19]), 32'd1);
    chk("swap_clear", 32'(swap_pending), 32'd0);
    cyc(0, 1, pix_addr(5, 2), 32'h1);
    chk("pix_bank0", 32'(fb_waddr), 32'h00805);

    // randomized traffic over several frames
    for (int i = 0; i < 4000; i++) begin
      wm = ($urandom_range(0, 3) != 0);
      k  = $urandom_range(0, 199);
      d  = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
      if (k < 130)      a = pix_addr($urandom_range(0, HV - 1), $urandom_range(0, VV - 1));
      else if (k < 150) a = pix_addr($urandom_range(HV, 1023), $urandom_range(0, VV - 1));
      else if (k < 170) a = pix_addr($urandom_range(0, HV - 1), $urandom_range(VV, 1023));
      else if (k < 190) a = {8'($urandom_range(0, 255) | 1), 24'($urandom)};
      else if (k < 192) a = 32'hF4FFFFFC;
      else              a = {8'hF4, 24'($urandom)};
      cyc(0, wm, a, d);
    end

    // swap request in the very commit clock: toggles now and again next frame
    cyc(0, 1, 32'hF4FFFFFC, 32'h0);
    idle_to_commit("swap2");
    b0 = fb_raddr[19];
    cyc(0, 1, 32'hF4FFFFFC, 32'h0);
    chk("set_wins_bank", 32'(fb_raddr[19]), 32'(!b0));
    chk("set_wins_pend", 32'(swap_pending), 32'd1);
    cyc(0, 0, '0, '0);
    idle_to_commit("swap3");
    cyc(0, 0, '0, '0);
    chk("second_toggle", 32'(fb_raddr[19]), 32'(b0));
    chk("second_clear", 32'(swap_pending), 32'd0);

    // reset mid-frame drops a pending swap and cancels a store
    repeat (37) cyc(0, 0, '0, '0);
    cyc(0, 1, 32'hF4FFFFFC, 32'h0);
    cyc(1, 1, pix_addr(1, 1), 32'h1);
    chk("rst_we", 32'(fb_we), 32'd0);
    chk("rst_pend", 32'(swap_pending), 32'd0);
    chk("rst_frame", 32'(fb_raddr), 32'd0);
    cyc(0, 1, pix_addr(2, 2), 32'h1);
    cyc(1, 0, '0, '0);
    chk("rst_inflight", 32'(fb_we), 32'd0);
    repeat (FRAME + 10) cyc(0, 0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
